// File: rtl/ifetch_serial.sv
// ifetch_serial: fetches NWORD 256-bit words from memory and streams them out byte by byte with valid/ready.
module ifetch_serial #(
  parameter int NWORD = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         mem_rd,
  output logic [1:0]   mem_addr,
  input  logic [255:0] mem_data,
  output logic [7:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic [6:0]   out_index
);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, DONE} state_t;
  localparam logic [1:0] LAST_WORD = 2'(NWORD - 1);
  state_t       state_q, state_d;
  logic [1:0]   word_q, word_d;
  logic [4:0]   byte_q, byte_d;
  logic [255:0] buf_q, buf_d;
  logic         send;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      byte_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      byte_q  <= byte_d;
      buf_q   <= buf_d;
    end
  end
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    byte_d  = byte_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = FETCH;
        word_d  = '0;
        byte_d  = '0;
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        buf_d   = mem_data;
        state_d = SEND;
      end
      SEND: if (out_ready) begin
        byte_d = byte_q + 5'd1;
        if (byte_q == 5'd31) begin
          state_d = (word_q == LAST_WORD) ? DONE : FETCH;
          word_d  = (word_q == LAST_WORD) ? word_q : word_q + 2'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Outputs decode straight from state so reset clears them without a clock edge.
  assign send      = state_q == SEND;
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign mem_rd    = state_q == FETCH;
  assign mem_addr  = (state_q == IDLE) ? 2'b00 : word_q;
  assign out_valid = send;
  assign out_data  = send ? buf_q[{byte_q, 3'b000} +: 8] : 8'h00;
  assign out_index = send ? {word_q, byte_q} : 7'h00;
  assign out_last  = send && byte_q == 5'd31 && word_q == LAST_WORD;
endmodule

// File: tb/tb_ifetch_serial.sv
// tb_ifetch_serial: randomized self-checking bench for ifetch_serial (NWORD=4 and NWORD=1 instances).
module tb_ifetch_serial;
  logic         clock = 0, reset_n = 0;
  logic         start = 0, out_ready = 1, start1 = 0, out_ready1 = 1;
  logic         busy, done, mem_rd, out_valid, out_last;
  logic         busy1, done1, mem_rd1, out_valid1, out_last1;
  logic [1:0]   mem_addr, mem_addr1;
  logic [255:0] mem_data = '0, mem_data1 = '0;
  logic [7:0]   out_data, out_data1;
  logic [6:0]   out_index, out_index1;
  logic [7:0]   mem_b [4][32];
  int checks = 0, errors = 0, cyc = 0, done_cyc = -1, dbl_rd = 0, last_bad = 0;
  logic [7:0] bq[$], stall_d[$];
  logic [6:0] iq[$], stall_ix[$];
  bit         lq[$];
  int         sc[$], sa[$];

  ifetch_serial #(.NWORD(4)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .out_index(out_index));
  ifetch_serial #(.NWORD(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .start(start1), .busy(busy1), .done(done1),
    .mem_rd(mem_rd1), .mem_addr(mem_addr1), .mem_data(mem_data1), .out_data(out_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_last(out_last1), .out_index(out_index1));

  always #5 clock = ~clock;

  function automatic logic [255:0] word_of(input logic [1:0] w);
    logic [255:0] r;
    for (int k = 0; k < 32; k++) r[8*k +: 8] = mem_b[w][k];
    return r;
  endfunction

  // Memory answers one cycle after a strobed cycle.
  always @(posedge clock) begin
    if (mem_rd) mem_data <= word_of(mem_addr);
    if (mem_rd1) mem_data1 <= word_of(mem_addr1);
  end

  task automatic tick;
    @(posedge clock);
    #1 cyc++;
  endtask

  task automatic fill(input bit rnd);
    for (int w = 0; w < 4; w++)
      for (int k = 0; k < 32; k++) mem_b[w][k] = rnd ? 8'($urandom) : 8'(w * 32 + k);
  endtask

  task automatic collect(input int stall_at, input bit rnd, input int pulse_idx, input int hold_idx);
    int  stall_left = 0;
    bit  stalled = 0, pulsed = 0, hold_on = 0, prev_rd = 0;
    bq.delete(); iq.delete(); lq.delete(); sc.delete(); sa.delete();
    stall_d.delete(); stall_ix.delete();
    dbl_rd = 0; last_bad = 0; done_cyc = -1;
    out_ready = 1;
    start = 1; cyc = 0;
    tick;
    start = 0;
    for (int g = 0; g < 2000; g++) begin
      if (mem_rd) begin
        sc.push_back(cyc); sa.push_back(int'(mem_addr));
        if (prev_rd) dbl_rd++;
      end
      prev_rd = mem_rd;
      if (out_last && !out_valid) last_bad++;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (hold_idx >= 0 && out_valid && int'(out_index) >= hold_idx) hold_on = 1;
      start = hold_on;
      if (!pulsed && pulse_idx >= 0 && out_valid && int'(out_index) == pulse_idx) begin
        start = 1; pulsed = 1;
      end
      if (stall_left > 0) begin
        out_ready = 0; stall_left--;
        stall_d.push_back(out_data); stall_ix.push_back(out_index);
      end else if (!stalled && stall_at >= 0 && out_valid && int'(out_index) == stall_at) begin
        stalled = 1; stall_left = 4; out_ready = 0;
        stall_d.push_back(out_data); stall_ix.push_back(out_index);
      end else out_ready = rnd ? 1'($urandom) : 1'b1;
      if (out_valid && out_ready) begin
        bq.push_back(out_data); iq.push_back(out_index); lq.push_back(out_last);
      end
      tick;
    end
    out_ready = 1;
  endtask

  task automatic test_reset;
    reset_n = 0;
    #2;
    checks++;
    if ({busy, done, mem_rd, mem_addr, out_valid, out_data, out_last, out_index} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b rd=%b addr=%0d valid=%b data=%h last=%b idx=%0d want all 0",
               busy, done, mem_rd, mem_addr, out_valid, out_data, out_last, out_index);
    end
    checks++;
    if ({busy1, done1, mem_rd1, out_valid1, out_last1} !== '0) begin
      errors++; $display("FAIL reset_outputs_n1 got busy=%b done=%b want 0", busy1, done1);
    end
    tick; tick;
    reset_n = 1;
    tick;
    checks++;
    if (busy !== 0 || done !== 0) begin
      errors++; $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_stream;
    fill(0);
    collect(-1, 0, -1, -1);
    checks++;
    if (bq.size() != 128) begin
      errors++; $display("FAIL stream_count got %0d want 128", bq.size());
    end
    for (int i = 0; i < bq.size(); i++) begin
      checks++;
      if (bq[i] !== mem_b[i / 32][i % 32] || iq[i] !== 7'(i) || lq[i] !== (i == 127)) begin
        errors++;
        $display("FAIL stream_byte %0d got data=%0d idx=%0d last=%b want data=%0d idx=%0d last=%b",
                 i, bq[i], iq[i], lq[i], mem_b[i / 32][i % 32], i, i == 127);
      end
    end
    checks++;
    if (done_cyc != 4 * 34 + 1) begin
      errors++; $display("FAIL done_cycle got %0d want 137", done_cyc);
    end
    checks++;
    if (sc.size() != 4 || dbl_rd != 0 || last_bad != 0) begin
      errors++; $display("FAIL strobe_count got %0d dbl=%0d lastbad=%0d want 4 0 0", sc.size(), dbl_rd, last_bad);
    end
    for (int i = 0; i < sc.size() && i < 4; i++) begin
      checks++;
      if (sc[i] != 1 + 34 * i || sa[i] != i) begin
        errors++; $display("FAIL strobe_%0d got cyc=%0d addr=%0d want cyc=%0d addr=%0d", i, sc[i], sa[i], 1 + 34 * i, i);
      end
    end
    checks++;
    if (busy !== 1) begin
      errors++; $display("FAIL busy_in_done got %b want 1", busy);
    end
    tick;
    checks++;
    if (busy !== 0 || done !== 0 || mem_addr !== 2'd0) begin
      errors++; $display("FAIL idle_after_done got busy=%b done=%b addr=%0d want 0 0 0", busy, done, mem_addr);
    end
  endtask

  task automatic test_stall_random;
    fill(1);
    collect(40, 1, -1, -1);
    checks++;
    if (bq.size() != 128 || last_bad != 0 || done_cyc < 0) begin
      errors++; $display("FAIL rand_count got %0d lastbad=%0d done=%0d want 128 0 seen", bq.size(), last_bad, done_cyc);
    end
    for (int i = 0; i < bq.size(); i++) begin
      checks++;
      if (bq[i] !== mem_b[i / 32][i % 32] || iq[i] !== 7'(i) || lq[i] !== (i == 127)) begin
        errors++;
        $display("FAIL rand_byte %0d got data=%h idx=%0d last=%b want data=%h idx=%0d last=%b",
                 i, bq[i], iq[i], lq[i], mem_b[i / 32][i % 32], i, i == 127);
      end
    end
    checks++;
    if (stall_d.size() != 5) begin
      errors++; $display("FAIL stall_len got %0d want 5", stall_d.size());
    end
    for (int i = 0; i < stall_d.size(); i++) begin
      checks++;
      if (stall_d[i] !== mem_b[1][8] || stall_ix[i] !== 7'd40) begin
        errors++; $display("FAIL stall_hold %0d got data=%h idx=%0d want data=%h idx=40", i, stall_d[i], stall_ix[i], mem_b[1][8]);
      end
    end
    tick;
  endtask

  task automatic test_back_to_back;
    int seen = -1;
    fill(1);
    collect(-1, 0, 40, 120);
    checks++;
    if (bq.size() != 128 || done_cyc != 137) begin
      errors++; $display("FAIL b2b_first got bytes=%0d done=%0d want 128 137", bq.size(), done_cyc);
    end
    for (int i = 0; i < bq.size(); i++) begin
      checks++;
      if (bq[i] !== mem_b[i / 32][i % 32] || iq[i] !== 7'(i)) begin
        errors++; $display("FAIL b2b_byte %0d got data=%h idx=%0d want data=%h", i, bq[i], iq[i], mem_b[i / 32][i % 32]);
      end
    end
    tick;
    checks++;
    if (busy !== 0) begin
      errors++; $display("FAIL b2b_gap got busy=%b want 0", busy);
    end
    tick;
    start = 0;
    checks++;
    if (busy !== 1 || mem_rd !== 1 || mem_addr !== 2'd0) begin
      errors++; $display("FAIL b2b_restart got busy=%b rd=%b addr=%0d want 1 1 0", busy, mem_rd, mem_addr);
    end
    for (int g = 0; g < 300 && seen < 0; g++) begin
      if (done) seen = g;
      tick;
    end
    checks++;
    if (seen < 0) begin
      errors++; $display("FAIL b2b_second_done got none want pulse");
    end
  endtask

  task automatic test_reset_midrun;
    int hits = 0;
    bit found = 0;
    fill(1);
    start = 1; tick; start = 0;
    for (int g = 0; g < 300 && !found; g++) begin
      if (out_valid && out_index == 7'd70) found = 1;
      else tick;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL reach_70 got none want index 70");
    end
    #2 reset_n = 0;
    #1;
    checks++;
    if ({out_valid, busy, mem_rd, done, out_index} !== '0) begin
      errors++; $display("FAIL async_reset got valid=%b busy=%b rd=%b done=%b idx=%0d want 0", out_valid, busy, mem_rd, done, out_index);
    end
    tick; tick;
    #3 reset_n = 1;
    for (int g = 0; g < 10; g++) begin
      tick;
      if (done || busy) hits++;
    end
    checks++;
    if (hits != 0) begin
      errors++; $display("FAIL reset_abandon got %0d active cycles want 0", hits);
    end
    collect(-1, 0, -1, -1);
    checks++;
    if (bq.size() != 128 || bq[0] !== mem_b[0][0] || iq[0] !== 7'd0 || done_cyc != 137) begin
      errors++; $display("FAIL after_reset_run got bytes=%0d first=%h idx0=%0d done=%0d want 128 %h 0 137",
                         bq.size(), bq.size() ? bq[0] : 8'h0, bq.size() ? iq[0] : 7'h0, done_cyc, mem_b[0][0]);
    end
    tick;
  endtask

  task automatic test_nword1;
    int nb = 0, d = -1, addr_bad = 0, last_at = -1, last_cnt = 0;
    fill(1);
    start1 = 1; cyc = 0; tick; start1 = 0;
    for (int g = 0; g < 100 && d < 0; g++) begin
      if (mem_addr1 !== 2'd0) addr_bad++;
      if (done1) d = cyc;
      if (out_last1) begin last_at = int'(out_index1); last_cnt++; end
      if (out_valid1) begin
        checks++;
        if (out_data1 !== mem_b[0][nb % 32] || out_index1 !== 7'(nb)) begin
          errors++; $display("FAIL n1_byte %0d got data=%h idx=%0d want data=%h", nb, out_data1, out_index1, mem_b[0][nb % 32]);
        end
        nb++;
      end
      if (d < 0) tick;
    end
    checks++;
    if (nb != 32 || d != 35 || addr_bad != 0 || last_at != 31 || last_cnt != 1) begin
      errors++; $display("FAIL n1_run got bytes=%0d done=%0d addrbad=%0d last=%0d x%0d want 32 35 0 31 x1",
                         nb, d, addr_bad, last_at, last_cnt);
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_stream;
    test_stall_random;
    test_back_to_back;
    test_reset_midrun;
    test_nword1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
